reg_ring_rotator: RTL and testbench
===================================

// Module: reg_ring_rotator
// PURPOSE
//  Parametrised ring of NUM_REGS WIDTH-bit registers rotating one position per step.
//  Generalises the two-register cross-swap testbench into a reusable block with per-slot valid bits.
//  Also adds a consume-gated rotation handshake, slot load/invalidate and a step counter.
//  Sits under test tops as the data source for VALID/CONSUMED-style register chains.
// PARAMETERS
//  WIDTH        32   data width of each slot
//  NUM_REGS     4    slot count, >= 2
//  INIT0        24   reset value of slot 0
//  INIT_STRIDE  21   slot i resets to INIT0 + i*INIT_STRIDE, truncated to WIDTH
//  CNT_W        16   STEP_COUNT width
//  (local) IDX_W = max(1, $clog2(NUM_REGS))
// PORTS
//  CLK                input  1      clock, all state on posedge
//  RST                input  1      synchronous reset, active-high
//  RUN                input  1      enable rotation
//  DIR                input  1      0 = left (r[i] <= r[i+1]), 1 = right (r[i] <= r[i-1]), indices mod NUM_REGS
//  LOAD_EN            input  1      write LOAD_DATA into slot LOAD_IDX
//  LOAD_IDX           input  IDX_W  slot to load
//  LOAD_DATA          input  WIDTH  load value
//  CLR_EN             input  1      clear valid bit of slot CLR_IDX
//  CLR_IDX            input  IDX_W  slot to invalidate
//  OUT_IDX            input  IDX_W  slot presented on OUT_READ
//  OUT_READ           output WIDTH  r[OUT_IDX], combinational; 0 when OUT_IDX >= NUM_REGS
//  OUT_READ_VALID     output 1      valid[OUT_IDX] && OUT_IDX < NUM_REGS
//  OUT_READ_CONSUMED  input  1      consumer accepts current value; permits a rotation
//  STEP_COUNT         output CNT_W  rotations since reset, wraps to 0
//  ROTATED            output 1      registered pulse, 1 in the cycle after a rotation
//  LOAD_ERR           output 1      sticky: LOAD_EN or CLR_EN seen with index >= NUM_REGS
// BEHAVIOUR
//  - Reset: r[i] = INIT0 + i*INIT_STRIDE, all valid = 1, STEP_COUNT = 0, ROTATED = 0, LOAD_ERR = 0.
//    Reset asserted mid-operation overrides every other input in that cycle.
//  - rot = RUN && all_valid && OUT_READ_CONSUMED && !LOAD_EN && !CLR_EN.
//    If rot: all slots shift one position per DIR in the same edge; STEP_COUNT += 1 (mod 2^CNT_W); ROTATED <= 1.
//    Otherwise ROTATED <= 0.
//  - Valid bits do not move on rotation; all are 1 whenever rotation occurs.
//  - Priority at one edge: RST > LOAD > CLR > rotate.
//    LOAD and CLR on the same legal index: load wins, slot ends valid. Different indices: both apply.
//  - Any valid bit = 0 stalls rotation.
//    A stall holds all slots and STEP_COUNT and keeps OUT_READ stable. Loading the slot re-validates it.
//    Rotation resumes in the next eligible cycle.
//  - Out-of-range LOAD_IDX/CLR_IDX: the write is ignored and LOAD_ERR <= 1.
//    The operation still blocks rotation that cycle.
//  - Latency: a load or rotation is visible on OUT_READ the cycle after the edge. No bypass.
//  - NUM_REGS = 2: DIR has no effect; the block behaves as a two-register swap.
// CONFIGURATION
//  RING_TRACE_EN defined:
//    - On negedge CLK, when !RST && all_valid, $display of all slots as "%d" separated by single spaces, slot 0 first.
//    - Simulation only, excluded from synthesis.
//  RING_TRACE_EN undefined: no trace code is compiled; ports and timing are identical.
// STRUCTURE
//  - Package reg_ring_pkg:
//    - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
//    - Function ring_idx_w(n) for IDX_W.
//    - Function ring_init(i, init0, stride).
//  - Sub-module reg_ring_slot: one WIDTH register plus valid bit.
//    - Inputs: load, clear, shift-in data, shift enable.
//    - Instantiated NUM_REGS times in a generate loop.
//  - Top holds rot logic, STEP_COUNT, ROTATED, LOAD_ERR and the output mux.
// TESTING
//  1. N=2, RUN=1, CONSUMED=1, OUT_IDX=0 after reset -> OUT_READ 24,45,24,45 on successive cycles; STEP_COUNT 0,1,2,3.
//  2. N=4, one rotation: DIR=0 -> slots [45,66,87,24]; DIR=1 from reset -> [87,24,45,66]; ROTATED pulses once.
//  3. CLR slot 2 -> OUT_IDX=2 VALID=0 and rotation/STEP_COUNT frozen with CONSUMED=1.
//     Then LOAD slot 2 = 100 -> VALID=1; rotation resumes the following cycle.
//  4. LOAD_EN with RUN=1, CONSUMED=1 -> slot loaded, no shift, STEP_COUNT unchanged.
//     CONSUMED=0 with RUN=1 -> no rotation.
//  5. N=4, LOAD_IDX=5 (IDX_W=2 widened in test via N=5, idx 6) -> no slot changes, LOAD_ERR=1, held until RST.
//  6. CNT_W=4, 16 rotations -> STEP_COUNT wraps to 0.
//     RST asserted mid-run -> slots back to INIT values and all outputs at reset values next cycle.

Source files
------------

// File: rtl/reg_ring_pkg.sv
// Shared constants and helpers for the register ring rotator.
package reg_ring_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Index width for n slots, never narrower than one bit.
    function automatic int ring_idx_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Reset value of slot i before truncation to the data width.
    function automatic logic [63:0] ring_init(input int i, input int init0, input int stride);
        return 64'(init0) + 64'(i) * 64'(stride);
    endfunction

endpackage

// File: rtl/reg_ring_slot.sv
// One ring slot: a data register plus its valid bit.
// Priority inside the slot: reset > load > clear/shift.
module reg_ring_slot #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_shift_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Slot state; a load re-validates, a clear only touches the valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= INIT;
            r_valid <= 1'b1;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_valid <= 1'b1;
        end else begin
            if (i_clear)    r_valid <= 1'b0;
            if (i_shift_en) r_data  <= i_shift_data;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/reg_ring_rotator.sv
// Ring of NUM_REGS registers rotating one position per consumed step.
// Optional simulation trace of the ring contents: define RING_TRACE_EN.
module reg_ring_rotator
    import reg_ring_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  NUM_REGS    = 4,
    parameter int  INIT0       = 24,
    parameter int  INIT_STRIDE = 21,
    parameter int  CNT_W       = 16,
    localparam int IDX_W       = ring_idx_w(NUM_REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_dir,
    input  logic             i_load_en,
    input  logic [IDX_W-1:0] i_load_idx,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic [IDX_W-1:0] i_out_idx,
    output logic [WIDTH-1:0] o_out_read,
    output logic             o_out_read_valid,
    input  logic             i_out_read_consumed,
    output logic [CNT_W-1:0] o_step_count,
    output logic             o_rotated,
    output logic             o_load_err
);

    logic [NUM_REGS-1:0][WIDTH-1:0] w_data;
    logic [NUM_REGS-1:0][WIDTH-1:0] w_shift_in;
    logic [NUM_REGS-1:0]            w_valid;
    logic [NUM_REGS-1:0]            w_ld;
    logic [NUM_REGS-1:0]            w_cl;
    logic                           w_load_ok;
    logic                           w_clr_ok;
    logic                           w_bad_idx;
    logic                           w_rot;

    logic [CNT_W-1:0] r_step_count;
    logic             r_rotated;
    logic             r_load_err;

    assign w_load_ok = i_load_en && (32'(i_load_idx) < NUM_REGS);
    assign w_clr_ok  = i_clr_en  && (32'(i_clr_idx)  < NUM_REGS);
    assign w_bad_idx = (i_load_en && !w_load_ok) || (i_clr_en && !w_clr_ok);

    // Any load/clear request, legal or not, blocks rotation in its cycle.
    assign w_rot = i_run && (&w_valid) && i_out_read_consumed && !i_load_en && !i_clr_en;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        localparam int NXT = (g + 1) % NUM_REGS;
        localparam int PRV = (g + NUM_REGS - 1) % NUM_REGS;

        assign w_shift_in[g] = (i_dir == DIR_LEFT) ? w_data[NXT] : w_data[PRV];
        assign w_ld[g]       = w_load_ok && (32'(i_load_idx) == g);
        // Load wins over clear on the same slot.
        assign w_cl[g]       = w_clr_ok && (32'(i_clr_idx) == g) && !w_ld[g];

        reg_ring_slot #(
            .WIDTH (WIDTH),
            .INIT  (WIDTH'(ring_init(g, INIT0, INIT_STRIDE)))
        ) u_slot (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_load       (w_ld[g]),
            .i_load_data  (i_load_data),
            .i_clear      (w_cl[g]),
            .i_shift_en   (w_rot),
            .i_shift_data (w_shift_in[g]),
            .o_data       (w_data[g]),
            .o_valid      (w_valid[g])
        );
    end

    // Step counter, rotation pulse and sticky bad-index flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step_count <= '0;
            r_rotated    <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            if (w_rot) r_step_count <= r_step_count + 1'b1;
            r_rotated <= w_rot;
            if (w_bad_idx) r_load_err <= 1'b1;
        end
    end

    // Read mux; out-of-range index reads as zero and invalid.
    always_comb begin
        o_out_read       = '0;
        o_out_read_valid = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(i_out_idx) == k) begin
                o_out_read       = w_data[k];
                o_out_read_valid = w_valid[k];
            end
        end
    end

    assign o_step_count = r_step_count;
    assign o_rotated    = r_rotated;
    assign o_load_err   = r_load_err;

`ifdef RING_TRACE_EN
    // Print the whole ring, slot 0 first, whenever every slot is valid.
    always @(negedge i_clk) begin
        if (!i_rst && (&w_valid)) begin
            string s;
            s = "";
            for (int k = 0; k < NUM_REGS; k++) begin
                s = (k == 0) ? $sformatf("%d", w_data[k]) : {s, " ", $sformatf("%d", w_data[k])};
            end
            $display("%s", s);
        end
    end
`else
`endif

endmodule

// File: tb/tb_reg_ring_rotator.sv
// Scoreboard bench: a five-slot ring with a 4-bit counter plus a two-slot swap instance.
module tb_reg_ring_rotator;

    localparam int W  = 32;
    localparam int N  = 5;
    localparam int CW = 4;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, run, dir, le, ce, cons;
    logic [IW-1:0] lidx, cidx, oidx;
    logic [W-1:0]  ldata;
    logic [W-1:0]  rd;
    logic          rv, rotd, lerr;
    logic [CW-1:0] sc;

    logic          run2;
    logic [W-1:0]  rd2;
    logic          rv2, rotd2, lerr2;
    logic [15:0]   sc2;

    reg_ring_rotator #(.WIDTH(W), .NUM_REGS(N), .INIT0(24), .INIT_STRIDE(21), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_dir(dir),
        .i_load_en(le), .i_load_idx(lidx), .i_load_data(ldata),
        .i_clr_en(ce), .i_clr_idx(cidx), .i_out_idx(oidx),
        .o_out_read(rd), .o_out_read_valid(rv), .i_out_read_consumed(cons),
        .o_step_count(sc), .o_rotated(rotd), .o_load_err(lerr)
    );

    reg_ring_rotator #(.WIDTH(W), .NUM_REGS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_run(run2), .i_dir(dir),
        .i_load_en(1'b0), .i_load_idx(1'b0), .i_load_data('0),
        .i_clr_en(1'b0), .i_clr_idx(1'b0), .i_out_idx(1'b0),
        .o_out_read(rd2), .o_out_read_valid(rv2), .i_out_read_consumed(1'b1),
        .o_step_count(sc2), .o_rotated(rotd2), .o_load_err(lerr2)
    );

    typedef struct {
        logic [W-1:0]  rd;
        logic          rv;
        logic [CW-1:0] sc;
        logic          rot;
        logic          err;
        logic [W-1:0]  rd2;
        logic [15:0]   sc2;
    } exp_t;

    exp_t q[$];

    logic [W-1:0]  mr [N];
    logic [N-1:0]  mv;
    logic [CW-1:0] mcnt;
    logic          mrot, merr;
    logic [W-1:0]  m2 [2];
    logic [15:0]   m2cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance the model with the currently driven inputs, push the expectation,
    // clock the DUT, then pop and compare.
    task automatic cyc();
        exp_t         e;
        logic         rot;
        logic [W-1:0] nr [N];
        logic [W-1:0] t;
        if (rst) begin
            for (int i = 0; i < N; i++) mr[i] = W'(24 + 21 * i);
            mv = '1; mcnt = '0; mrot = 1'b0; merr = 1'b0;
            m2[0] = 24; m2[1] = 45; m2cnt = '0;
        end else begin
            rot = run && (&mv) && cons && !le && !ce;
            if (le) begin
                if (int'(lidx) < N) begin mr[lidx] = ldata; mv[lidx] = 1'b1; end
                else merr = 1'b1;
            end
            if (ce) begin
                if (int'(cidx) < N) begin
                    if (!(le && lidx == cidx)) mv[cidx] = 1'b0;
                end else merr = 1'b1;
            end
            if (rot) begin
                nr = mr;
                for (int i = 0; i < N; i++) mr[i] = dir ? nr[(i + N - 1) % N] : nr[(i + 1) % N];
                mcnt = mcnt + 1'b1;
            end
            mrot = rot;
            if (run2) begin
                t = m2[0]; m2[0] = m2[1]; m2[1] = t;
                m2cnt = m2cnt + 1'b1;
            end
        end
        e.rd  = (int'(oidx) < N) ? mr[oidx] : '0;
        e.rv  = (int'(oidx) < N) ? mv[oidx] : 1'b0;
        e.sc  = mcnt;
        e.rot = mrot;
        e.err = merr;
        e.rd2 = m2[0];
        e.sc2 = m2cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("out_read", rd, e.rd);
        chk("out_valid", rv, e.rv);
        chk("step_count", sc, e.sc);
        chk("rotated", rotd, e.rot);
        chk("load_err", lerr, e.err);
        chk("swap_read", rd2, e.rd2);
        chk("swap_count", sc2, e.sc2);
    endtask

    task automatic idle();
        run = 0; le = 0; ce = 0; cons = 0;
    endtask

    initial begin
        rst = 1; run = 0; dir = 0; le = 0; ce = 0; cons = 0;
        lidx = 0; cidx = 0; oidx = 0; ldata = 0; run2 = 1;

        // Reset state, two-slot swap 24,45,24,45 alongside.
        cyc();
        chk("rst_slot0", rd, 24);
        chk("rst_cnt", sc, 0);
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("swap_seq", rd2, (k % 2 == 0) ? 45 : 24);
        end
        run2 = 0;
        for (int k = 0; k < N; k++) begin oidx = IW'(k); cyc(); end

        // One left rotation.
        run = 1; cons = 1; dir = 0; oidx = 4;
        cyc();
        chk("rotL_s4", rd, 24);
        chk("rotL_pulse", rotd, 1);
        idle();
        for (int k = 0; k < N; k++) begin oidx = IW'(k); cyc(); end

        // One right rotation from reset.
        rst = 1; cyc(); rst = 0;
        run = 1; cons = 1; dir = 1; oidx = 0;
        cyc();
        chk("rotR_s0", rd, 108);
        idle(); cyc();
        chk("rot_pulse_end", rotd, 0);

        // Clear slot 2 stalls rotation; loading it resumes.
        run = 1; cons = 1; dir = 0; ce = 1; cidx = 2; oidx = 2;
        cyc();
        chk("clr_valid", rv, 0);
        ce = 0;
        cyc(); cyc();
        chk("stall_cnt", sc, 1);
        le = 1; lidx = 2; ldata = 100;
        cyc();
        chk("reload_valid", rv, 1);
        le = 0;
        cyc(); cyc();

        // Load blocks rotation; CONSUMED low blocks rotation.
        le = 1; lidx = 0; ldata = 32'hDEAD_BEEF; oidx = 0;
        cyc();
        le = 0; cons = 0;
        cyc(); cyc();

        // Load and clear together: same slot, then different slots.
        le = 1; ce = 1; lidx = 3; cidx = 3; ldata = 7; oidx = 3;
        cyc();
        lidx = 1; cidx = 4; ldata = 9; oidx = 4;
        cyc();
        le = 0; ce = 0; run = 1; cons = 1;
        cyc();
        le = 1; lidx = 4; ldata = 11;
        cyc();

        // Out-of-range indices: ignored writes, sticky error, zero read.
        le = 1; lidx = 6; ldata = 55; oidx = 6;
        cyc();
        chk("oor_read", rd, 0);
        chk("oor_err", lerr, 1);
        le = 0; ce = 1; cidx = 7; oidx = 1;
        cyc();
        ce = 0;
        cyc(); cyc();

        // Counter wrap after 16 rotations, then reset mid-run.
        rst = 1; cyc(); rst = 0;
        run = 1; cons = 1; dir = 0; oidx = 0;
        for (int k = 0; k < 16; k++) cyc();
        chk("cnt_wrap", sc, 0);
        cyc(); cyc();
        rst = 1; cyc(); rst = 0;
        chk("midrst_slot0", rd, 24);
        idle();

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            rst   = ($urandom_range(0, 39) == 0);
            run   = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1);
            cons  = ($urandom_range(0, 4) != 0);
            le    = ($urandom_range(0, 7) == 0);
            ce    = ($urandom_range(0, 7) == 0);
            lidx  = IW'($urandom_range(0, 7));
            cidx  = IW'($urandom_range(0, 7));
            oidx  = IW'($urandom_range(0, 7));
            ldata = $urandom;
            run2  = $urandom_range(0, 1);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
